axi_uart_tx_fifo: RTL and testbench

// - AXI4-Lite slave UART for the NPC sim SoC. Replaces the single-shot print stub with a

---
 rtl/axi_uart_tx_fifo.sv | 171 +++++++++++++++++
 tb/tb_axi_uart_tx_fifo.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_uart_tx_fifo.sv
// AXI4-Lite UART transmit block: TXDATA/STATUS/DIV register window feeding a TX FIFO
// that is drained onto tx_byte/tx_valid at one byte per DIV cycles.
module axi_uart_tx_fifo #(
    parameter logic [31:0] BASE_ADDR  = 32'ha000_03f8,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET  = 16'd1,
    parameter bit          SIM_PRINT  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        awvalid,
    input  logic [31:0] awaddr,
    output logic        awready,
    input  logic        wvalid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        wready,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    input  logic        arvalid,
    input  logic [31:0] araddr,
    output logic        arready,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        tx_valid,
    output logic [7:0]  tx_byte
);
    // state  | meaning
    // W_IDLE | waiting for AW and W to be valid together
    // W_ACC  | awready/wready pulse, write takes effect at the end of this cycle
    // W_RESP | bvalid held until bready
    typedef enum logic [1:0] {W_IDLE, W_ACC, W_RESP} wr_state_t;

    localparam int AW = $clog2(FIFO_DEPTH);

    wr_state_t wr_state, wr_next;
    logic [31:0] aw_off, ar_off, rd_mux;
    logic        aw_hit, ar_hit, wr_fire, ar_fire, push_req, push, drain;
    logic [1:0]  aw_sel, ar_sel, bresp_q;
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, count;
    logic        full, empty;
    logic [15:0] div_q, cnt;
    logic        arready_q, rvalid_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic        unused_bits;

    assign unused_bits = ^{wdata[31:16], wstrb[3:2]};

    assign aw_off = awaddr - BASE_ADDR;
    assign ar_off = araddr - BASE_ADDR;
    assign aw_hit = aw_off < 32'd12;
    assign ar_hit = ar_off < 32'd12;
    assign aw_sel = aw_off[3:2];
    assign ar_sel = ar_off[3:2];

    always_ff @(posedge clk) begin
        if (rst) wr_state <= W_IDLE;
        else     wr_state <= wr_next;
    end

    always_comb begin
        wr_next = wr_state;
        unique case (wr_state)
            W_IDLE:  if (awvalid && wvalid) wr_next = W_ACC;
            W_ACC:   wr_next = (awvalid && wvalid) ? W_RESP : W_IDLE;
            W_RESP:  if (bready) wr_next = W_IDLE;
            default: wr_next = W_IDLE;
        endcase
    end

    always_comb begin
        awready = (wr_state == W_ACC);
        wready  = (wr_state == W_ACC);
        bvalid  = (wr_state == W_RESP);
    end

    assign bresp    = bresp_q;
    assign wr_fire  = (wr_state == W_ACC) && awvalid && wvalid;
    assign push_req = wr_fire && aw_hit && (aw_sel == 2'd0) && wstrb[0];
    // Full is judged on the pre-pop occupancy, so a simultaneous drain does not rescue the push.
    assign push     = push_req && !full;

    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            bresp_q <= 2'b00;
            div_q   <= DIV_RESET;
        end else begin
            if (push)  wr_ptr <= wr_ptr + (AW+1)'(1);
            if (drain) rd_ptr <= rd_ptr + (AW+1)'(1);
            if (wr_fire) begin
                if (!aw_hit)                 bresp_q <= 2'b11;
                else if (push_req && full)   bresp_q <= 2'b10;
                else                         bresp_q <= 2'b00;
                if (aw_hit && aw_sel == 2'd2 && wstrb[1:0] == 2'b11)
                    div_q <= (wdata[15:0] == 16'd0) ? 16'd1 : wdata[15:0];
            end
        end
    end

    // >= rather than == so a DIV shrunk below the running count drains at once instead of wrapping.
    assign drain    = !empty && (cnt >= div_q - 16'd1);
    assign tx_valid = drain;
    assign tx_byte  = drain ? mem[rd_ptr[AW-1:0]] : 8'h00;

    always_ff @(posedge clk) begin
        if (rst || empty || drain) cnt <= 16'd0;
        else                       cnt <= cnt + 16'd1;
    end

    always_comb begin
        rd_mux = 32'h0;
        if (ar_hit) begin
            case (ar_sel)
                2'd1:    rd_mux = {16'h0, 8'(count), 6'h0, empty, full};
                2'd2:    rd_mux = {16'h0, div_q};
                default: rd_mux = 32'h0;
            endcase
        end
    end

    assign ar_fire = arready_q && arvalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'h0;
            rresp_q   <= 2'b00;
        end else begin
            arready_q <= arvalid && !rvalid_q && !arready_q;
            if (ar_fire) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_mux;
                rresp_q  <= ar_hit ? 2'b00 : 2'b11;
            end else if (rvalid_q && rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;

`ifndef SYNTHESIS
    generate
        if (SIM_PRINT) begin : g_print
            always_ff @(posedge clk) begin
                if (!rst && tx_valid) $write("%c", tx_byte);
            end
        end
    endgenerate
`endif

endmodule

// File: tb/tb_axi_uart_tx_fifo.sv
// Scoreboard bench for axi_uart_tx_fifo: directed register/FIFO scenarios plus random traffic,
// checked against a queue-based model of the register map and drain timing.
module tb_axi_uart_tx_fifo;
    localparam logic [31:0] BASE  = 32'ha000_03f8;
    localparam int          DEPTH = 16;

    logic        clk, rst;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        arvalid, arready, rvalid, rready, tx_valid;
    logic [7:0]  tx_byte;

    axi_uart_tx_fifo #(
        .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .DIV_RESET(16'd1), .SIM_PRINT(1'b0)
    ) dut (
        .clk(clk), .rst(rst),
        .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
        .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wready(wready),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .araddr(araddr), .arready(arready),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .tx_valid(tx_valid), .tx_byte(tx_byte)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out", name);
    endtask

    // Reference model: FIFO contents, divisor, and the cycle at which the head byte is due.
    logic [7:0]  mq[$];
    logic [1:0]  bq[$];
    logic [33:0] rq[$];
    int          div_m = 1;
    longint      cyc = 0;
    longint      due = 0;
    logic        r_hold = 1'b0;
    logic [33:0] r_prev;

    function automatic logic [33:0] read_expect(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        if (off >= 32'd12) return {2'b11, 32'h0};
        case (off / 4)
            1:       return {2'b00, 16'h0, 8'(mq.size()), 6'h0, mq.size() == 0, mq.size() == DEPTH};
            2:       return {2'b00, 16'h0, 16'(div_m)};
            default: return 34'h0;
        endcase
    endfunction

    always @(negedge clk) begin
        bit          exp_tx;
        logic [31:0] off;
        logic [1:0]  e;
        cyc++;
        if (rst) begin
            mq.delete(); bq.delete(); rq.delete();
            div_m  = 1;
            r_hold = 1'b0;
        end else begin
            exp_tx = (mq.size() > 0) && (cyc == due);
            chk("tx_valid", tx_valid, exp_tx);
            if (exp_tx && tx_valid) chk("tx_byte", tx_byte, mq[0]);
            if (bvalid) chk("awready_while_bvalid", awready, 0);
            if (r_hold) chk("r_stable", {rvalid, rresp, rdata}, {1'b1, r_prev});
            if (arready && arvalid) rq.push_back(read_expect(araddr));
            if (awready && awvalid && wvalid) begin
                off = awaddr - BASE;
                e = 2'b00;
                if (off >= 32'd12) e = 2'b11;
                else if (off / 4 == 0 && wstrb[0]) begin
                    if (mq.size() >= DEPTH) e = 2'b10;
                    else begin
                        if (mq.size() == 0) due = cyc + div_m;
                        mq.push_back(wdata[7:0]);
                    end
                end else if (off / 4 == 2 && wstrb[1:0] == 2'b11)
                    div_m = (wdata[15:0] == 16'd0) ? 1 : int'(wdata[15:0]);
                bq.push_back(e);
            end
            if (exp_tx) begin
                void'(mq.pop_front());
                if (mq.size() > 0) due = cyc + div_m;
            end
            if (bvalid && bready) begin
                if (bq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL bresp: unexpected response %b", bresp);
                end else chk("bresp", bresp, bq.pop_front());
            end
            if (rvalid && rready) begin
                if (rq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rdata: unexpected response %b/%h", rresp, rdata);
                end else chk("rresp_rdata", {rresp, rdata}, rq.pop_front());
            end
            r_hold = rvalid && !rready;
            r_prev = {rresp, rdata};
        end
    end

    task automatic wait_b();
        int n;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bvalid) break;
        end
        if (n == 200) fail_now("bvalid_wait");
        @(posedge clk); #1 bready = 1'b0;
    endtask

    task automatic wait_aw();
        int n;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (awready) break;
        end
        if (n == 200) fail_now("awready_wait");
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int bdly);
        @(posedge clk); #1;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        wait_aw();
        awvalid = 1'b0; wvalid = 1'b0;
        repeat (bdly) @(posedge clk);
        #1 bready = 1'b1;
        wait_b();
    endtask

    task automatic rd(input logic [31:0] a, input int rdly, output logic [31:0] d, output logic [1:0] r);
        int n;
        @(posedge clk); #1;
        araddr = a; arvalid = 1'b1; rready = 1'b0;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (arready) break;
        end
        if (n == 200) fail_now("arready_wait");
        @(posedge clk); #1 arvalid = 1'b0;
        repeat (rdly) @(posedge clk);
        #1 rready = 1'b1;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (rvalid) break;
        end
        if (n == 200) fail_now("rvalid_wait");
        d = rdata; r = rresp;
        @(posedge clk); #1 rready = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        for (n = 0; n < budget; n++) begin
            @(negedge clk);
            if (mq.size() == 0) break;
        end
        if (n == budget) fail_now("drain_wait");
        repeat (2) @(posedge clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_awready"}, awready, 0);
        chk({tag, "_wready"}, wready, 0);
        chk({tag, "_bvalid"}, bvalid, 0);
        chk({tag, "_bresp"}, bresp, 0);
        chk({tag, "_arready"}, arready, 0);
        chk({tag, "_rvalid"}, rvalid, 0);
        chk({tag, "_rdata"}, rdata, 0);
        chk({tag, "_rresp"}, rresp, 0);
        chk({tag, "_tx_valid"}, tx_valid, 0);
        chk({tag, "_tx_byte"}, tx_byte, 0);
    endtask

    logic [31:0] d;
    logic [1:0]  r;
    bit          saw;

    initial begin
        rst = 1'b1; awvalid = 0; wvalid = 0; awaddr = 0; wdata = 0; wstrb = 0;
        bready = 0; arvalid = 0; araddr = 0; rready = 0;
        repeat (3) @(posedge clk);
        #1 check_zero("reset");
        rst = 1'b0;

        wr(BASE, 32'h41, 4'hf, 0);
        wait_drain(100);
        rd(BASE + 4, 0, d, r);
        chk("status_idle", d, 32'h2);

        wr(BASE + 8, 32'd4, 4'b0011, 0);
        rd(BASE + 8, 1, d, r);
        chk("div_readback", d, 32'd4);
        wr(BASE, 32'h61, 4'h1, 0);
        wr(BASE, 32'h62, 4'h1, 0);
        wr(BASE, 32'h63, 4'h1, 0);
        for (int i = 0; i < 4; i++) rd(BASE + 4, 0, d, r);
        wait_drain(200);

        wr(BASE + 8, 32'd100, 4'b0011, 0);
        for (int i = 0; i <= DEPTH; i++) wr(BASE, 32'h20 + i, 4'h1, 0);
        rd(BASE + 4, 0, d, r);
        chk("status_full", d, 32'h1001);
        wait_drain(3000);

        rd(BASE + 32'hc, 0, d, r);
        chk("decerr_rresp", r, 2'b11);
        chk("decerr_rdata", d, 0);
        wr(BASE, 32'h7e, 4'b0010, 0);
        wr(BASE - 4, 32'h7f, 4'hf, 1);
        rd(BASE + 4, 0, d, r);
        chk("no_push_strb", d, 32'h2);
        wr(BASE + 8, 32'd0, 4'b0011, 0);
        rd(BASE + 8, 0, d, r);
        chk("div_zero_is_one", d, 32'd1);

        @(posedge clk); #1;
        awaddr = BASE; wdata = 32'h55; wstrb = 4'h1; awvalid = 1; wvalid = 1; bready = 0;
        wait_aw();
        wdata = 32'h56;
        saw = 0;
        repeat (5) begin
            @(negedge clk);
            if (awready) saw = 1;
            chk("bvalid_held", bvalid, 1);
        end
        chk("no_second_accept", saw, 0);
        @(posedge clk); #1 bready = 1'b1;
        wait_b();
        wait_aw();
        awvalid = 0; wvalid = 0; bready = 1'b1;
        wait_b();
        rd(BASE + 8, 5, d, r);
        wait_drain(100);

        wr(BASE + 8, 32'd100, 4'b0011, 0);
        for (int i = 0; i < 5; i++) wr(BASE, 32'h30 + i, 4'h1, 0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 check_zero("midrst");
        rst = 1'b0;
        rd(BASE + 4, 0, d, r);
        chk("status_after_rst", d, 32'h2);

        for (int k = 0; k < 150; k++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op <= 5)
                wr(BASE, $urandom, ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0001, $urandom_range(0, 3));
            else if (op <= 7)
                rd(BASE + 4 * $urandom_range(0, 3), $urandom_range(0, 3), d, r);
            else if (op == 8) begin
                case ($urandom_range(0, 3))
                    0: wr(BASE + 4, $urandom, 4'hf, $urandom_range(0, 2));
                    1: wr(BASE + 32'hc, $urandom, 4'hf, 0);
                    2: wr(BASE + 32'h100, $urandom, 4'hf, 1);
                    default: wr(BASE, $urandom, 4'b1110, 0);
                endcase
            end else if (mq.size() == 0)
                wr(BASE + 8, $urandom_range(0, 5), ($urandom_range(0, 3) == 0) ? 4'b0001 : 4'b0011, 0);
        end
        wait_drain(2000);
        chk("bq_empty", bq.size(), 0);
        chk("rq_empty", rq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
